ddr_fill_writer: RTL and testbench
==================================

DDR_FILL_WRITER -- requirements
Module: ddr_fill_writer

Interface
REQ-001 Parameter DATA_W, 128, payload width per burst (tag bits excluded).
REQ-002 Parameter TAG_W, 4, tag field width at top of FIFO word.
REQ-003 Parameter ADDR_W, 23, burst-address width; app_addr = {addr, 3'b0}.
REQ-004 Parameter BURST_W, 24, width of burst/total counters.
REQ-005 Parameter START_LSB, 53, LSB of ADDR_W-bit start-address field in fill header.
REQ-006 Parameter AHEAD_MAX, 16, max bursts of data accepted ahead of addresses (>=1, <=255).
REQ-007 Ports SHALL be: clk in 1 clock; reset in 1 synchronous active-high reset; acq_enabled in 1 writing enabled, low forces IDLE; acq_done in 1 async acquisition-done level; resync in 1 pulse, leave SYNC_ERR.
REQ-008 Ports SHALL be: fifo_dat in DATA_W+TAG_W FWFT FIFO head; fifo_empty in 1; fifo_rd_en out 1 pop head.
REQ-009 Ports SHALL be: app_wdf_wren out 1; app_wdf_end out 1; app_wdf_rdy in 1; app_en out 1; app_rdy in 1; app_addr out ADDR_W+3.
REQ-010 Ports SHALL be: fixed_start_addr in ADDR_W; en_fixed_start in 1; ring_base in ADDR_W; ring_limit in ADDR_W (inclusive, >= ring_base).
REQ-011 Ports SHALL be: hdr_dat out DATA_W+BURST_W {total_bursts, header payload}; hdr_wr_en out 1; hdr_full in 1; sync_err out 1; wr_done out 1; err_count out 8 sync errors since reset.

Function
REQ-012 acq_done SHALL pass through a 2-flop synchronizer before use.
REQ-013 States: IDLE, TST_TAG, SYNC_ERR, INIT_FILL, INIT_WFM, INIT_CKSM, WRITE, WRITE_CKSM, WAIT_HDR, WRITE_HDR, DONE; one-hot.
REQ-014 IDLE -> TST_TAG when !fifo_empty; else stay.
REQ-015 TST_TAG (one cycle): tag 1 -> INIT_FILL, 2 -> INIT_WFM, 4 -> INIT_CKSM, other -> SYNC_ERR.
REQ-016 Tag 1 in TST_TAG SHALL latch fifo_dat[DATA_W-1:0] into header register.
REQ-017 INIT_FILL: addr <= en_fixed_start ? fixed_start_addr : fifo_dat[START_LSB+ADDR_W-1:START_LSB]; addr_cnt=burst_cnt=1; total=1; -> WRITE.
REQ-018 INIT_WFM: addr_cnt=burst_cnt=fifo_dat[BURST_W-2:0]+1 (header included); address unchanged; -> WRITE.
REQ-019 INIT_CKSM: addr_cnt=burst_cnt=1; -> WRITE_CKSM.
REQ-020 In WRITE/WRITE_CKSM: app_wdf_wren = app_wdf_end = !fifo_empty && burst_cnt!=0 && ahead<AHEAD_MAX; fifo_rd_en = app_wdf_wren && app_wdf_rdy.
REQ-021 In WRITE/WRITE_CKSM: app_en = addr_cnt!=0 && ahead!=0; address never precedes its data.
REQ-022 ahead counter: +1 on data accept only, -1 on address accept only, unchanged when both or neither.
REQ-023 Address accept (app_en&&app_rdy): addr <= (addr==ring_limit) ? ring_base : addr+1; addr_cnt-1; total+1 saturating at all-ones.
REQ-024 Data accept decrements burst_cnt; counters never go below 0.
REQ-025 WRITE exits to IDLE, WRITE_CKSM to WAIT_HDR, when burst_cnt==0 && addr_cnt==0.
REQ-026 Entering WAIT_HDR SHALL copy total into hdr_dat[DATA_W+BURST_W-1:DATA_W].
REQ-027 WAIT_HDR -> WRITE_HDR when !hdr_full; WRITE_HDR asserts hdr_wr_en one cycle, -> DONE.
REQ-028 DONE: wr_done=1; -> IDLE on synced acq_done.
REQ-029 SYNC_ERR: sync_err=1; err_count+1 (saturating at 255) on entry; -> IDLE on resync.
REQ-030 All flag outputs registered off next state; handshake outputs combinational from current state and counters.

Reset
REQ-031 reset SHALL zero all counters, addr, ahead, hdr_dat, err_count, all outputs, state IDLE.
REQ-032 !acq_enabled SHALL force IDLE next cycle, abandoning any transfer mid-fill; counters, address, err_count retained.
REQ-033 Reset mid-WRITE SHALL deassert app_en, app_wdf_wren, fifo_rd_en on the following cycle.

Verification
REQ-034 Fill hdr start 0x100, wfm burst=3, cksm, rdy always 1 -> addresses 0x100..0x105, 6 data pops, hdr total=6, hdr_wr_en one pulse, wr_done high.
REQ-035 ring_base=0x10, ring_limit=0x12, start 0x12, wfm burst=2 -> addresses 0x12,0x10,0x11,0x12.
REQ-036 app_rdy held 0 for 40 cycles with data ready -> exactly AHEAD_MAX(16) data accepts, wren drops, resumes on app_rdy.
REQ-037 Tag 3 at head -> sync_err=1, err_count=1; resync pulse -> IDLE; next valid fill completes normally.
REQ-038 hdr_full=1 at checksum end for 10 cycles -> state WAIT_HDR, no hdr_wr_en; release -> single hdr_wr_en.
REQ-039 acq_enabled dropped mid-waveform -> IDLE next cycle, all handshake outputs 0.

Source files
------------

// File: rtl/ddr_fill_writer.sv
// ddr_fill_writer: drains tagged fill/waveform/checksum words from a FWFT FIFO into DDR bursts,
// then hands the fill header plus the total burst count to the header FIFO.
module ddr_fill_writer #(
   parameter int DATA_W    = 128,
   parameter int TAG_W     = 4,
   parameter int ADDR_W    = 23,
   parameter int BURST_W   = 24,
   parameter int START_LSB = 53,
   parameter int AHEAD_MAX = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      acq_enabled,
   input  logic                      acq_done,
   input  logic                      resync,
   input  logic [DATA_W+TAG_W-1:0]   fifo_dat,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   input  logic                      app_wdf_rdy,
   output logic                      app_en,
   input  logic                      app_rdy,
   output logic [ADDR_W+2:0]         app_addr,
   input  logic [ADDR_W-1:0]         fixed_start_addr,
   input  logic                      en_fixed_start,
   input  logic [ADDR_W-1:0]         ring_base,
   input  logic [ADDR_W-1:0]         ring_limit,
   output logic [DATA_W+BURST_W-1:0] hdr_dat,
   output logic                      hdr_wr_en,
   input  logic                      hdr_full,
   output logic                      sync_err,
   output logic                      wr_done,
   output logic [7:0]                err_count
);
   typedef enum logic [10:0] {
      IDLE       = 11'd1,
      TST_TAG    = 11'd2,
      SYNC_ERR   = 11'd4,
      INIT_FILL  = 11'd8,
      INIT_WFM   = 11'd16,
      INIT_CKSM  = 11'd32,
      WRITE      = 11'd64,
      WRITE_CKSM = 11'd128,
      WAIT_HDR   = 11'd256,
      WRITE_HDR  = 11'd512,
      DONE       = 11'd1024
   } state_t;

   localparam logic [TAG_W-1:0] TAG_FILL = TAG_W'(1);
   localparam logic [TAG_W-1:0] TAG_WFM = TAG_W'(2);
   localparam logic [TAG_W-1:0] TAG_CKSM = TAG_W'(4);
   localparam logic [7:0] AHEAD_LIM = 8'(AHEAD_MAX);

   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BURST_W-1:0] addr_cnt_q, addr_cnt_d, burst_cnt_q, burst_cnt_d, total_q, total_d, wfm_cnt;
   logic [7:0] ahead_q, ahead_d, err_q, err_d;
   logic skip_q, skip_d;
   logic [DATA_W+BURST_W-1:0] hdr_q, hdr_d;
   logic [1:0] done_s_q;
   logic sync_err_q, wr_done_q, hdr_wr_en_q;
   logic [TAG_W-1:0] tag;
   logic in_wr, cnt_zero, data_acc, addr_acc;

   assign tag = fifo_dat[DATA_W+TAG_W-1:DATA_W];
   assign cnt_zero = burst_cnt_q == '0 && addr_cnt_q == '0;
   assign wfm_cnt = {1'b0, fifo_dat[BURST_W-2:0]} + 1'b1;
   assign app_addr = {addr_q, 3'b000};
   assign hdr_dat = hdr_q;
   assign hdr_wr_en = hdr_wr_en_q;
   assign sync_err = sync_err_q;
   assign wr_done = wr_done_q;
   assign err_count = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sync_err_q <= 1'b0;
         wr_done_q <= 1'b0;
         hdr_wr_en_q <= 1'b0;
         done_s_q <= 2'b00;
      end else begin
         state_q <= state_d;
         sync_err_q <= state_d == SYNC_ERR;
         wr_done_q <= state_d == DONE;
         hdr_wr_en_q <= state_d == WRITE_HDR;
         done_s_q <= {done_s_q[0], acq_done};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       state_d = fifo_empty ? IDLE : TST_TAG;
         TST_TAG:    state_d = tag == TAG_FILL ? INIT_FILL : tag == TAG_WFM ? INIT_WFM :
                               tag == TAG_CKSM ? INIT_CKSM : SYNC_ERR;
         SYNC_ERR:   state_d = resync ? IDLE : SYNC_ERR;
         INIT_FILL:  state_d = WRITE;
         INIT_WFM:   state_d = WRITE;
         INIT_CKSM:  state_d = WRITE_CKSM;
         WRITE:      state_d = cnt_zero ? IDLE : WRITE;
         WRITE_CKSM: state_d = cnt_zero ? WAIT_HDR : WRITE_CKSM;
         WAIT_HDR:   state_d = hdr_full ? WAIT_HDR : WRITE_HDR;
         WRITE_HDR:  state_d = DONE;
         DONE:       state_d = done_s_q[1] ? IDLE : DONE;
         default:    state_d = IDLE;
      endcase
      if (!acq_enabled)
         state_d = IDLE;
   end

   // ahead counts data beats not yet addressed, so an address can never overtake its data
   always_comb begin
      in_wr = state_q == WRITE || state_q == WRITE_CKSM;
      app_wdf_wren = in_wr && !fifo_empty && burst_cnt_q != '0 && ahead_q < AHEAD_LIM;
      app_wdf_end = app_wdf_wren;
      fifo_rd_en = app_wdf_wren && app_wdf_rdy;
      app_en = in_wr && addr_cnt_q != '0 && ahead_q != '0;
      data_acc = fifo_rd_en;
      addr_acc = app_en && app_rdy;
   end

   always_comb begin
      addr_d = addr_q;
      addr_cnt_d = addr_cnt_q;
      burst_cnt_d = burst_cnt_q;
      total_d = total_q;
      ahead_d = ahead_q;
      skip_d = skip_q;
      hdr_d = hdr_q;
      err_d = err_q;
      if (state_q == TST_TAG && tag == TAG_FILL)
         hdr_d[DATA_W-1:0] = fifo_dat[DATA_W-1:0];
      if (state_q == INIT_FILL) begin
         addr_d = en_fixed_start ? fixed_start_addr : fifo_dat[START_LSB+ADDR_W-1:START_LSB];
         total_d = BURST_W'(1);
         skip_d = 1'b1;
      end
      if (state_q == INIT_FILL || state_q == INIT_CKSM) begin
         addr_cnt_d = BURST_W'(1);
         burst_cnt_d = BURST_W'(1);
      end
      if (state_q == INIT_WFM) begin
         addr_cnt_d = wfm_cnt;
         burst_cnt_d = wfm_cnt;
      end
      if (state_q == INIT_FILL || state_q == INIT_WFM || state_q == INIT_CKSM)
         ahead_d = '0;
      // the fill burst is pre-counted in total, so its own address accept adds nothing
      if (addr_acc) begin
         addr_d = addr_q == ring_limit ? ring_base : addr_q + 1'b1;
         addr_cnt_d = addr_cnt_q - 1'b1;
         total_d = (skip_q || &total_q) ? total_q : total_q + 1'b1;
         skip_d = 1'b0;
      end
      if (data_acc)
         burst_cnt_d = burst_cnt_q - 1'b1;
      if (data_acc && !addr_acc)
         ahead_d = ahead_q + 8'd1;
      else if (addr_acc && !data_acc)
         ahead_d = ahead_q - 8'd1;
      if (state_d == WAIT_HDR && state_q != WAIT_HDR)
         hdr_d[DATA_W+BURST_W-1:DATA_W] = total_q;
      if (state_d == SYNC_ERR && state_q != SYNC_ERR && err_q != 8'hFF)
         err_d = err_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         addr_cnt_q <= '0;
         burst_cnt_q <= '0;
         total_q <= '0;
         ahead_q <= '0;
         skip_q <= 1'b0;
         hdr_q <= '0;
         err_q <= '0;
      end else begin
         addr_q <= addr_d;
         addr_cnt_q <= addr_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         total_q <= total_d;
         ahead_q <= ahead_d;
         skip_q <= skip_d;
         hdr_q <= hdr_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_ddr_fill_writer.sv
// tb_ddr_fill_writer: table of complete fill sequences plus directed stall, sync-error,
// header back-pressure, disable and reset sequences against a FWFT FIFO and DDR port model.
module tb_ddr_fill_writer;
   localparam int DW = 128;
   localparam int TW = 4;
   localparam int AW = 23;
   localparam int BW = 24;

   typedef struct packed {
      logic             en_fix;
      logic [AW-1:0]    fix;
      logic [AW-1:0]    hstart;
      logic [AW-1:0]    rbase;
      logic [AW-1:0]    rlim;
      logic [7:0]       burst;
      logic [7:0]       n;
      logic [5:0][25:0] ea;
   } vec_t;

   logic clk = 1'b0;
   logic reset, acq_enabled, acq_done, resync, fifo_empty, fifo_rd_en;
   logic app_wdf_wren, app_wdf_end, app_wdf_rdy, app_en, app_rdy, en_fixed_start;
   logic hdr_wr_en, hdr_full, sync_err, wr_done;
   logic [DW+TW-1:0] fifo_dat;
   logic [AW+2:0] app_addr;
   logic [AW-1:0] fixed_start_addr, ring_base, ring_limit;
   logic [DW+BW-1:0] hdr_dat, hdr_cap;
   logic [7:0] err_count;

   logic [DW+TW-1:0] mem [1024];
   int rp = 0, wp = 0;
   logic flush = 1'b0;
   logic [AW+2:0] got_a [256];
   int n_addr = 0, n_data = 0, n_pop = 0, n_hdr = 0, viol = 0;
   int n_chk = 0, n_fail = 0;
   vec_t tv [3];

   ddr_fill_writer dut (
      .clk(clk), .reset(reset), .acq_enabled(acq_enabled), .acq_done(acq_done), .resync(resync),
      .fifo_dat(fifo_dat), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .app_en(app_en), .app_rdy(app_rdy), .app_addr(app_addr),
      .fixed_start_addr(fixed_start_addr), .en_fixed_start(en_fixed_start),
      .ring_base(ring_base), .ring_limit(ring_limit),
      .hdr_dat(hdr_dat), .hdr_wr_en(hdr_wr_en), .hdr_full(hdr_full),
      .sync_err(sync_err), .wr_done(wr_done), .err_count(err_count)
   );

   always #5 clk = ~clk;

   assign fifo_dat = mem[rp];
   assign fifo_empty = rp == wp;

   always @(posedge clk)
      rp <= flush ? wp : rp + (fifo_rd_en ? 1 : 0);

   always @(negedge clk) begin
      if (app_en && app_rdy) begin
         if (n_addr < 256) got_a[n_addr] = app_addr;
         n_addr++;
      end
      if (app_wdf_wren && app_wdf_rdy) n_data++;
      if (fifo_rd_en) n_pop++;
      if (hdr_wr_en) begin
         n_hdr++;
         hdr_cap = hdr_dat;
      end
      if (n_addr > n_data || app_wdf_wren !== app_wdf_end) viol++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required completion before timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0][25:0] al(input logic [25:0] a0, a1, a2, a3, a4, a5);
      return {a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic push(input logic [TW-1:0] t, input logic [DW-1:0] p);
      mem[wp] = {t, p};
      wp++;
   endtask

   task automatic push_fill(input logic [AW-1:0] st, output logic [DW-1:0] pl);
      pl = (DW'(st) << 53) | 128'h5A5A_0000_C3C3;
      push(4'd1, pl);
   endtask

   task automatic push_wfm(input int burst);
      push(4'd2, DW'(burst));
      for (int i = 0; i < burst; i++) push(4'd0, DW'(i) + 128'h77);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm);
      for (int k = 0; k < 400 && !wr_done; k++) cyc(1);
      chk({nm, " wr_done"}, 160'(wr_done), 160'(1));
   endtask

   task automatic end_done(input string nm);
      acq_done = 1'b1;
      cyc(4);
      chk({nm, " idle after acq_done"}, 160'(wr_done), 160'(0));
      acq_done = 1'b0;
      cyc(3);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int a0, p0, h0;
      logic [DW-1:0] pl;
      string nm;
      nm = $sformatf("vec%0d", k);
      en_fixed_start = v.en_fix;
      fixed_start_addr = v.fix;
      ring_base = v.rbase;
      ring_limit = v.rlim;
      a0 = n_addr;
      p0 = n_pop;
      h0 = n_hdr;
      push_fill(v.hstart, pl);
      push_wfm(int'(v.burst));
      push(4'd4, 128'hC5C5);
      wait_done(nm);
      chk({nm, " addr count"}, 160'(n_addr - a0), 160'(v.n));
      for (int i = 0; i < int'(v.n); i++)
         chk($sformatf("%s addr%0d", nm, i), 160'(got_a[a0+i]), 160'(v.ea[i]));
      chk({nm, " pops"}, 160'(n_pop - p0), 160'(v.n));
      chk({nm, " hdr pulses"}, 160'(n_hdr - h0), 160'(1));
      chk({nm, " hdr_dat"}, 160'(hdr_cap), 160'({BW'(v.n), pl}));
      end_done(nm);
   endtask

   initial begin
      int a0, d0, h0;
      logic [DW-1:0] pl;
      tv[0] = '{1'b0, 23'h0, 23'h100, 23'h0, 23'h7FFFFF, 8'd3, 8'd6,
                al(26'h800, 26'h808, 26'h810, 26'h818, 26'h820, 26'h828)};
      tv[1] = '{1'b1, 23'h12, 23'h55, 23'h10, 23'h12, 8'd2, 8'd5,
                al(26'h90, 26'h80, 26'h88, 26'h90, 26'h80, 26'h0)};
      tv[2] = '{1'b0, 23'h0, 23'h7FFFFF, 23'h7FFFFD, 23'h7FFFFF, 8'd0, 8'd3,
                al(26'h3FFFFF8, 26'h3FFFFE8, 26'h3FFFFF0, 26'h0, 26'h0, 26'h0)};
      reset = 1'b1;
      acq_enabled = 1'b1;
      acq_done = 1'b0;
      resync = 1'b0;
      app_wdf_rdy = 1'b1;
      app_rdy = 1'b1;
      hdr_full = 1'b0;
      en_fixed_start = 1'b0;
      fixed_start_addr = '0;
      ring_base = '0;
      ring_limit = 23'h7FFFFF;
      cyc(3);
      chk("reset handshakes", 160'({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en}), 160'(0));
      chk("reset flags", 160'({hdr_wr_en, sync_err, wr_done}), 160'(0));
      chk("reset err_count", 160'(err_count), 160'(0));
      chk("reset hdr_dat", 160'(hdr_dat), 160'(0));
      chk("reset app_addr", 160'(app_addr), 160'(0));
      reset = 1'b0;
      cyc(2);

      for (int k = 0; k < 3; k++) run_vec(tv[k], k);

      // data runs ahead of a stalled address channel by at most AHEAD_MAX beats
      en_fixed_start = 1'b0;
      ring_base = '0;
      ring_limit = 23'h7FFFFF;
      a0 = n_addr;
      push_fill(23'h200, pl);
      for (int k = 0; k < 50 && n_addr == a0; k++) cyc(1);
      chk("stall fill addr", 160'(n_addr - a0), 160'(1));
      app_rdy = 1'b0;
      d0 = n_data;
      push_wfm(20);
      push(4'd4, 128'hC5C5);
      cyc(40);
      chk("stall data accepts", 160'(n_data - d0), 160'(16));
      chk("stall wren low", 160'(app_wdf_wren), 160'(0));
      chk("stall app_en high", 160'(app_en), 160'(1));
      app_rdy = 1'b1;
      cyc(3);
      chk("stall resumed", 160'(n_data - d0 > 16), 160'(1));
      wait_done("stall");
      chk("stall data total", 160'(n_data - d0), 160'(22));
      chk("stall hdr total", 160'(hdr_cap), 160'({BW'(23), pl}));
      chk("stall last addr", 160'(got_a[n_addr-1]), 160'(26'h10B0));
      end_done("stall");

      // bad tag, recovery by resync
      h0 = n_pop;
      push(4'd3, 128'h0);
      cyc(5);
      chk("syncerr flag", 160'(sync_err), 160'(1));
      chk("syncerr count", 160'(err_count), 160'(1));
      chk("syncerr no pop", 160'(n_pop - h0), 160'(0));
      do_flush();
      resync = 1'b1;
      cyc(1);
      resync = 1'b0;
      cyc(1);
      chk("syncerr cleared", 160'(sync_err), 160'(0));
      run_vec(tv[0], 3);
      chk("syncerr count kept", 160'(err_count), 160'(1));

      // header FIFO full holds the record back
      hdr_full = 1'b1;
      a0 = n_addr;
      h0 = n_hdr;
      push_fill(23'h300, pl);
      push_wfm(1);
      push(4'd4, 128'hC5C5);
      for (int k = 0; k < 100 && n_addr - a0 < 4; k++) cyc(1);
      cyc(10);
      chk("hdrfull addrs", 160'(n_addr - a0), 160'(4));
      chk("hdrfull no pulse", 160'(n_hdr - h0), 160'(0));
      chk("hdrfull not done", 160'(wr_done), 160'(0));
      hdr_full = 1'b0;
      wait_done("hdrfull");
      chk("hdrfull one pulse", 160'(n_hdr - h0), 160'(1));
      chk("hdrfull hdr_dat", 160'(hdr_cap), 160'({BW'(4), pl}));
      end_done("hdrfull");

      // disable mid-waveform abandons the transfer
      d0 = n_data;
      push_fill(23'h400, pl);
      push_wfm(10);
      for (int k = 0; k < 100 && n_data - d0 < 5; k++) cyc(1);
      acq_enabled = 1'b0;
      cyc(1);
      chk("disable handshakes", 160'({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en}), 160'(0));
      chk("disable flags", 160'({hdr_wr_en, sync_err, wr_done}), 160'(0));
      do_flush();
      cyc(2);
      chk("disable stays idle", 160'({app_en, app_wdf_wren}), 160'(0));
      acq_enabled = 1'b1;
      run_vec(tv[1], 4);

      // reset while a data beat is pending
      app_wdf_rdy = 1'b0;
      push_fill(23'h500, pl);
      cyc(6);
      chk("prereset wren", 160'(app_wdf_wren), 160'(1));
      reset = 1'b1;
      flush = 1'b1;
      cyc(1);
      chk("midreset handshakes", 160'({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en}), 160'(0));
      chk("midreset err_count", 160'(err_count), 160'(0));
      chk("midreset hdr_dat", 160'(hdr_dat), 160'(0));
      reset = 1'b0;
      flush = 1'b0;
      app_wdf_rdy = 1'b1;
      cyc(2);
      run_vec(tv[2], 5);

      chk("pops equal data beats", 160'(n_pop), 160'(n_data));
      chk("ordering violations", 160'(viol), 160'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
